// File: rtl/ac97_pkg.sv
// -----------------------------------------------------------------------------
// ac97_pkg
// Shared constants for the AC97 slot link: the frame geometry, the tag bit
// positions and a helper that locates a slot inside a 256-bit frame vector.
// Frame vectors are stored with frame bit 0 (the first bit on the wire) in
// vector bit [FRAME_BITS-1], so a frame reads MSB-first like the wire.
// -----------------------------------------------------------------------------
package ac97_pkg;

   localparam int SLOT_W     = 20;
   localparam int FRAME_BITS = 256;
   localparam int TAG_W      = 16;
   localparam int MAX_SLOTS  = 12;

   // Tag bit positions (bit 15 is the first tag bit on the wire).
   localparam int TAG_READY_BIT = 15;
   localparam int TAG_SLOT1_BIT = 14;
   localparam int TAG_SLOT2_BIT = 13;
   localparam int TAG_SLOT3_BIT = 12;
   localparam int TAG_SLOT4_BIT = 11;

   // Bit-counter landmarks.
   localparam logic [7:0] BIT_LAST  = 8'hFF;
   localparam logic [7:0] SYNC_LAST = 8'd14;

   // Field layout inside slot 1 (status address) and slot 2 (status data).
   localparam int STATUS_ADDR_W   = 7;
   localparam int STATUS_ADDR_MSB = 18;
   localparam int STATUS_DATA_W   = 16;

   // Vector index of the MSB of slot 'slot' (1-based) in a frame vector.
   function automatic int slot_msb(input int slot);
      return FRAME_BITS - TAG_W - 1 - SLOT_W * (slot - 1);
   endfunction

endpackage

// File: rtl/ac97_deframer.sv
// -----------------------------------------------------------------------------
// ac97_deframer
// Receive side of the AC97 link. Serial data from the codec is captured on the
// falling edge (mid-bit) and shifted into a 256-bit frame register on the
// rising edge. When a complete frame is present it decodes the tag, updates
// codec_ready and loads status / PCM fields with one-cycle valid pulses.
//
// Ports:
//   clk_i            bit clock
//   rst_i            synchronous active-high reset
//   sdata_i          serial data from the codec
//   bitcnt_i         transmit bit counter (frame position)
//   codec_ready_o    input tag bit 15 of the last complete frame
//   status_addr_o    slot 1 bits [18:12]
//   status_data_o    slot 2 bits [19:4]
//   status_valid_o   one-cycle pulse on a status capture
//   left_o / right_o slots 3 / 4, top SAMPLE_W bits
//   pcm_valid_o      one-cycle pulse on a PCM capture
// -----------------------------------------------------------------------------
module ac97_deframer
   import ac97_pkg::*;
#(
   parameter int SAMPLE_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sdata_i,
   input  logic [7:0]          bitcnt_i,
   output logic                codec_ready_o,
   output logic [6:0]          status_addr_o,
   output logic [15:0]         status_data_o,
   output logic                status_valid_o,
   output logic [SAMPLE_W-1:0] left_o,
   output logic [SAMPLE_W-1:0] right_o,
   output logic                pcm_valid_o
);

   localparam int TAG_LSB_POS = FRAME_BITS - TAG_W;
   localparam int POS_READY   = TAG_LSB_POS + TAG_READY_BIT;
   localparam int POS_S1      = TAG_LSB_POS + TAG_SLOT1_BIT;
   localparam int POS_S2      = TAG_LSB_POS + TAG_SLOT2_BIT;
   localparam int POS_S3      = TAG_LSB_POS + TAG_SLOT3_BIT;
   localparam int POS_S4      = TAG_LSB_POS + TAG_SLOT4_BIT;
   localparam int POS_ADDR    = slot_msb(1) - (SLOT_W - 1 - STATUS_ADDR_MSB);
   localparam int POS_DATA    = slot_msb(2);
   localparam int POS_LEFT    = slot_msb(3);
   localparam int POS_RIGHT   = slot_msb(4);

   logic                  sdata_neg_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  armed_q;
   logic                  ready_q;
   logic [6:0]            addr_q;
   logic [15:0]           data_q;
   logic                  svalid_q;
   logic [SAMPLE_W-1:0]   left_q;
   logic [SAMPLE_W-1:0]   right_q;
   logic                  pvalid_q;

   // Mid-bit sample: the codec launches on the rising edge.
   always_ff @(negedge clk_i) begin
      sdata_neg_q <= sdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q  <= '0;
         armed_q  <= 1'b0;
         ready_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         svalid_q <= 1'b0;
         left_q   <= '0;
         right_q  <= '0;
         pvalid_q <= 1'b0;
      end else begin
         shift_q  <= {shift_q[FRAME_BITS-2:0], sdata_neg_q};
         svalid_q <= 1'b0;
         pvalid_q <= 1'b0;
         // At this edge bit 0 of a new frame enters, so shift_q still holds
         // the previous full frame. armed_q keeps the first, partial frame
         // after reset from being decoded.
         if (bitcnt_i == 8'd0) begin
            armed_q <= 1'b1;
            if (armed_q) begin
               ready_q <= shift_q[POS_READY];
               if (shift_q[POS_S1] && shift_q[POS_S2]) begin
                  addr_q   <= shift_q[POS_ADDR -: STATUS_ADDR_W];
                  data_q   <= shift_q[POS_DATA -: STATUS_DATA_W];
                  svalid_q <= 1'b1;
               end
               if (shift_q[POS_S3] && shift_q[POS_S4]) begin
                  left_q   <= shift_q[POS_LEFT -: SAMPLE_W];
                  right_q  <= shift_q[POS_RIGHT -: SAMPLE_W];
                  pvalid_q <= 1'b1;
               end
            end
         end
      end
   end

   assign codec_ready_o  = ready_q;
   assign status_addr_o  = addr_q;
   assign status_data_o  = data_q;
   assign status_valid_o = svalid_q;
   assign left_o         = left_q;
   assign right_o        = right_q;
   assign pcm_valid_o    = pvalid_q;

endmodule

// File: rtl/ac97_slot_link.sv
// -----------------------------------------------------------------------------
// ac97_slot_link
// AC97 controller-side slot link. A free-running 8-bit bit counter defines a
// 256-bit frame. Slot payloads are sampled at the strobe edge and serialised
// during the following frame; the receive path lives in ac97_deframer.
//
// Ports:
//   ac97_bitclk       codec bit clock (only clock)
//   ac97_rst          synchronous active-high reset
//   ac97_sdata_in     serial data from codec
//   ac97_sdata_out    serial data to codec (registered)
//   ac97_sync         frame sync (registered), high for bitcnt 255 and 0..14
//   ac97_strobe       high while bitcnt == 0
//   out_slots         NUM_OUT_SLOTS x 20-bit payloads, slot 1 in [19:0]
//   out_valid         per-slot valid, bit 0 is slot 1
//   codec_ready, status_addr, status_data, status_valid,
//   in_left, in_right, in_pcm_valid   decoded receive fields
//
// Optional feature, macro AC97_SLOT_LINK_STATS_EN: adds frame_cnt (wrapping,
// counts strobes) and status_cnt (saturating, counts status_valid pulses).
// -----------------------------------------------------------------------------
module ac97_slot_link
   import ac97_pkg::*;
#(
   parameter int NUM_OUT_SLOTS = 12,
   parameter int SAMPLE_W      = 16
) (
   input  logic                          ac97_bitclk,
   input  logic                          ac97_rst,
   input  logic                          ac97_sdata_in,
   output logic                          ac97_sdata_out,
   output logic                          ac97_sync,
   output logic                          ac97_strobe,
   input  logic [NUM_OUT_SLOTS*SLOT_W-1:0] out_slots,
   input  logic [NUM_OUT_SLOTS-1:0]      out_valid,
   output logic                          codec_ready,
   output logic [6:0]                    status_addr,
   output logic [15:0]                   status_data,
   output logic                          status_valid,
   output logic [SAMPLE_W-1:0]           in_left,
   output logic [SAMPLE_W-1:0]           in_right,
   output logic                          in_pcm_valid
`ifdef AC97_SLOT_LINK_STATS_EN
   ,
   output logic [15:0]                   frame_cnt,
   output logic [15:0]                   status_cnt
`endif
);

   // The leading tag bit is always 1, so only the remaining 255 bits of the
   // frame image are stored.
   localparam int PAY_W     = FRAME_BITS - 1;
   localparam int TAG_PAD_W = TAG_W - 1 - MAX_SLOTS;

   logic [7:0]                bitcnt_q;
   logic [7:0]                bitcnt_d;
   logic [PAY_W-1:0]          sample_q;
   logic [PAY_W-1:0]          tx_q;
   logic [PAY_W-1:0]          img_d;
   logic [FRAME_BITS-1:0]     frame_img;
   logic                      sdata_q;
   logic                      sdata_d;
   logic                      sync_q;
   logic                      sync_d;
   logic [MAX_SLOTS-1:0]      tag_valid;
   logic [MAX_SLOTS*SLOT_W-1:0] slot_field;

   // Build the frame image: tag valid bits (slot 1 first) then slot payloads
   // (slot 1 first). Unconfigured or invalid slots are zero.
   generate
      for (genvar gi = 0; gi < MAX_SLOTS; gi++) begin : g_slot
         if (gi < NUM_OUT_SLOTS) begin : g_drv
            assign tag_valid[MAX_SLOTS-1-gi] = out_valid[gi];
            assign slot_field[(MAX_SLOTS-gi)*SLOT_W-1 -: SLOT_W] =
               out_valid[gi] ? out_slots[gi*SLOT_W +: SLOT_W] : '0;
         end else begin : g_idle
            assign tag_valid[MAX_SLOTS-1-gi] = 1'b0;
            assign slot_field[(MAX_SLOTS-gi)*SLOT_W-1 -: SLOT_W] = '0;
         end
      end
   endgenerate

   assign img_d     = {tag_valid, {TAG_PAD_W{1'b0}}, slot_field};
   assign frame_img = {1'b1, tx_q};
   assign bitcnt_d  = bitcnt_q + 8'd1;

   // Outputs are registered, so they are computed from the next count.
   // Frame bit n sits at vector index 255-n, which is ~n for an 8-bit n.
   // tx_q is reloaded at the same edge that launches bit 0; bit 0 is the
   // constant leading 1, so using the old tx_q there is harmless.
   assign sdata_d = frame_img[~bitcnt_d];
   assign sync_d  = (bitcnt_d == BIT_LAST) || (bitcnt_d <= SYNC_LAST);

   always_ff @(posedge ac97_bitclk) begin
      if (ac97_rst) begin
         bitcnt_q <= BIT_LAST;
         sample_q <= '0;
         tx_q     <= '0;
         sdata_q  <= 1'b0;
         sync_q   <= 1'b0;
      end else begin
         bitcnt_q <= bitcnt_d;
         sdata_q  <= sdata_d;
         sync_q   <= sync_d;
         // Two-stage image: sampled at the strobe edge, handed to the
         // serialiser at the frame boundary, giving exactly one frame latency.
         if (bitcnt_q == 8'd0) begin
            sample_q <= img_d;
         end
         if (bitcnt_q == BIT_LAST) begin
            tx_q <= sample_q;
         end
      end
   end

   assign ac97_sdata_out = sdata_q;
   assign ac97_sync      = sync_q;
   assign ac97_strobe    = (bitcnt_q == 8'd0);

   ac97_deframer #(
      .SAMPLE_W (SAMPLE_W)
   ) u_deframer (
      .clk_i          (ac97_bitclk),
      .rst_i          (ac97_rst),
      .sdata_i        (ac97_sdata_in),
      .bitcnt_i       (bitcnt_q),
      .codec_ready_o  (codec_ready),
      .status_addr_o  (status_addr),
      .status_data_o  (status_data),
      .status_valid_o (status_valid),
      .left_o         (in_left),
      .right_o        (in_right),
      .pcm_valid_o    (in_pcm_valid)
   );

`ifdef AC97_SLOT_LINK_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [15:0] status_cnt_q;

   always_ff @(posedge ac97_bitclk) begin
      if (ac97_rst) begin
         frame_cnt_q  <= '0;
         status_cnt_q <= '0;
      end else begin
         if (bitcnt_q == 8'd0) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (status_valid && (status_cnt_q != 16'hFFFF)) begin
            status_cnt_q <= status_cnt_q + 16'd1;
         end
      end
   end

   assign frame_cnt  = frame_cnt_q;
   assign status_cnt = status_cnt_q;
`endif

endmodule
